// File: rtl/nib_link_pkg.sv
// Shared definitions for the nibble link transmitter: link select codes,
// FSM state encoding and the default sample FIFO depth.
package nib_link_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    // {threshold,Higher} select codes as seen by the receiving filter
    localparam logic [1:0] SEL_INST_LO = 2'b00;
    localparam logic [1:0] SEL_INST_HI = 2'b01;
    localparam logic [1:0] SEL_TH_LO   = 2'b10;
    localparam logic [1:0] SEL_TH_HI   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        S_LO,
        S_HI,
        T_LO,
        T_HI
    } state_t;

endpackage

// File: rtl/nib_link_fifo.sv
// Synchronous 8-bit sample FIFO, DEPTH entries (power of 2). Push is ignored
// when full, pop is ignored when empty; rdata shows the head entry.
module nib_link_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nib_link_tx.sv
// Transmit end of the 4-bit nibble link: serialises buffered samples and
// threshold updates as nibble pairs. Define NIB_LINK_TX_CNT_EN for tx_cnt.
module nib_link_tx
    import nib_link_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] th_data,
    input  logic       th_load,
    output logic [3:0] nib,
    output logic       threshold,
    output logic       Higher,
    output logic       busy
`ifdef NIB_LINK_TX_CNT_EN
    ,
    output logic [7:0] tx_cnt
`endif
);

    state_t     state;
    logic [1:0] sel;
    logic [3:0] s_hi_nib;
    logic [3:0] last_lo;
    logic [3:0] th_cur_hi;
    logic [7:0] th_pend_val;
    logic       th_pend;

    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_push;
    logic       fifo_pop;

    logic       boundary;
    logic       go_th;
    logic       go_s;
    logic       bypass;
    logic [7:0] next_sample;

    nib_link_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (s_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A sample arriving at an idle boundary with nothing queued skips the
    // FIFO so its low nibble reaches the link on the very next cycle.
    assign boundary    = (state == IDLE) || (state == S_HI) || (state == T_HI);
    assign go_th       = boundary && th_pend;
    assign go_s        = boundary && !th_pend && (!fifo_empty || s_valid);
    assign bypass      = boundary && !th_pend && fifo_empty && s_valid;
    assign fifo_pop    = go_s && !fifo_empty;
    assign fifo_push   = s_valid && !fifo_full && !bypass;
    assign next_sample = fifo_empty ? s_data : fifo_rdata;

    assign s_ready   = !fifo_full;
    assign threshold = sel[1];
    assign Higher    = sel[0];
    assign busy      = (state != IDLE) || !fifo_empty || th_pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sel         <= SEL_INST_LO;
            nib         <= '0;
            s_hi_nib    <= '0;
            last_lo     <= '0;
            th_cur_hi   <= '0;
            th_pend_val <= '0;
            th_pend     <= 1'b0;
        end else begin
            // A load coinciding with T_LO entry re-arms pending for a later pair
            if (th_load) begin
                th_pend     <= 1'b1;
                th_pend_val <= th_data;
            end else if (go_th) begin
                th_pend     <= 1'b0;
            end

            if (go_th) begin
                state     <= T_LO;
                sel       <= SEL_TH_LO;
                nib       <= th_pend_val[3:0];
                th_cur_hi <= th_pend_val[7:4];
            end else if (go_s) begin
                state    <= S_LO;
                sel      <= SEL_INST_LO;
                nib      <= next_sample[3:0];
                last_lo  <= next_sample[3:0];
                s_hi_nib <= next_sample[7:4];
            end else begin
                case (state)
                    S_LO: begin
                        state <= S_HI;
                        sel   <= SEL_INST_HI;
                        nib   <= s_hi_nib;
                    end
                    T_LO: begin
                        state <= T_HI;
                        sel   <= SEL_TH_HI;
                        nib   <= th_cur_hi;
                    end
                    default: begin
                        // Idle code rewrites the receiver's inst low nibble unchanged
                        state <= IDLE;
                        sel   <= SEL_INST_LO;
                        nib   <= last_lo;
                    end
                endcase
            end
        end
    end

`ifdef NIB_LINK_TX_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               tx_cnt <= '0;
        else if (state == S_LO) tx_cnt <= tx_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_nib_link_tx.sv
// Directed bench for nib_link_tx with a small receiver model of the filter's
// inst/threshold registers. Checks tx_cnt when NIB_LINK_TX_CNT_EN is defined.
module tb_nib_link_tx;

    localparam int DEPTH = 4;
    localparam int N4    = DEPTH + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] th_data = '0;
    logic       th_load = 1'b0;
    logic [3:0] nib;
    logic       threshold;
    logic       Higher;
    logic       busy;
`ifdef NIB_LINK_TX_CNT_EN
    logic [7:0] tx_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] rx_inst;
    logic [7:0] rx_th;

    nib_link_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .th_data   (th_data),
        .th_load   (th_load),
        .nib       (nib),
        .threshold (threshold),
        .Higher    (Higher),
        .busy      (busy)
`ifdef NIB_LINK_TX_CNT_EN
        ,
        .tx_cnt    (tx_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Receiver model: writes one register nibble every clock from the link
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_inst <= '0;
            rx_th   <= '0;
        end else begin
            case ({threshold, Higher})
                2'b00: rx_inst[3:0] <= nib;
                2'b01: rx_inst[7:4] <= nib;
                2'b10: rx_th[3:0]   <= nib;
                2'b11: rx_th[7:4]   <= nib;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_link(input string tag, input logic [1:0] s, input logic [3:0] n);
        chk(tag, {26'd0, threshold, Higher, nib}, {26'd0, s, n});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] t4_val(input int i);
        return 8'(i * 37 + 11);
    endfunction

    initial begin
        logic [7:0] exp_q[$];
        logic [3:0] lo;
        logic       acc;
        logic       saw_full;
        int         sent;
        int         rcv;

        // 1: reset, idle link for 10 clocks
        repeat (3) tick();
        #2 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_link("t1_link", 2'b00, 4'h0);
            chk("t1_busy", busy, 1'b0);
            chk("t1_ready", s_ready, 1'b1);
        end

        // 2: single sample 0xA5, one-cycle latency
        s_data = 8'hA5; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk_link("t2_lo", 2'b00, 4'h5);
        chk("t2_busy", busy, 1'b1);
        tick(); chk_link("t2_hi", 2'b01, 4'hA);
        tick(); chk_link("t2_idle", 2'b00, 4'h5);
        tick();
        chk("t2_rx_inst", rx_inst, 8'hA5);
        chk("t2_busy_end", busy, 1'b0);

        // 3: threshold first, then two back-to-back samples
        th_data = 8'h40; th_load = 1'b1;
        tick();
        th_load = 1'b0;
        chk_link("t3_idle", 2'b00, 4'h5);
        s_data = 8'h30; s_valid = 1'b1;
        tick(); chk_link("t3_tlo", 2'b10, 4'h0);
        s_data = 8'h50;
        tick(); chk_link("t3_thi", 2'b11, 4'h4);
        s_valid = 1'b0;
        tick(); chk_link("t3_s1lo", 2'b00, 4'h0);
        tick(); chk_link("t3_s1hi", 2'b01, 4'h3);
        tick(); chk_link("t3_s2lo", 2'b00, 4'h0);
        tick(); chk_link("t3_s2hi", 2'b01, 4'h5);
        tick(); chk_link("t3_idle2", 2'b00, 4'h0);
        chk("t3_rx_inst", rx_inst, 8'h50);
        chk("t3_rx_th", rx_th, 8'h40);

        // 4: continuous stream long enough to fill the FIFO
        sent = 0; rcv = 0; saw_full = 1'b0; lo = '0;
        for (int c = 0; c < 200 && rcv < N4; c++) begin
            s_valid = (sent < N4);
            s_data  = t4_val(sent);
            acc     = s_valid && s_ready;
            if (s_valid && !s_ready) saw_full = 1'b1;
            tick();
            if (acc) begin
                exp_q.push_back(s_data);
                sent++;
            end
            if ({threshold, Higher} == 2'b00) begin
                lo = nib;
            end else if ({threshold, Higher} == 2'b01) begin
                chk("t4_data", {23'd0, 1'b0, nib, lo},
                    (exp_q.size() != 0) ? {23'd0, 1'b0, exp_q.pop_front()} : 32'h1FF);
                rcv++;
            end
        end
        s_valid = 1'b0;
        chk("t4_count", rcv, N4);
        chk("t4_full_seen", saw_full, 1'b1);
        tick();
        chk_link("t4_idle", 2'b00, t4_val(N4 - 1) & 8'h0F);
        chk("t4_busy_end", busy, 1'b0);

        // 5: load landing on the T_LO entry cycle of a pending threshold
        th_data = 8'h20; th_load = 1'b1;
        tick();
        th_data = 8'h10;
        tick(); chk_link("t5_p1lo", 2'b10, 4'h0);
        th_load = 1'b0;
        tick(); chk_link("t5_p1hi", 2'b11, 4'h2);
        tick(); chk_link("t5_p2lo", 2'b10, 4'h0);
        tick(); chk_link("t5_p2hi", 2'b11, 4'h1);
        tick(); chk("t5_busy_end", busy, 1'b0);
        chk("t5_rx_th", rx_th, 8'h10);

        // 6: reset during S_HI with a queued sample and a pending threshold
        s_data = 8'hC3; s_valid = 1'b1;
        tick(); chk_link("t6_lo", 2'b00, 4'h3);
        s_data = 8'h77; th_data = 8'h99; th_load = 1'b1;
        tick(); chk_link("t6_hi", 2'b01, 4'hC);
        s_valid = 1'b0; th_load = 1'b0;
        chk("t6_busy_pre", busy, 1'b1);
`ifdef NIB_LINK_TX_CNT_EN
        chk("cnt_pre_rst", tx_cnt, 8'd16);
`endif
        #2 rst = 1'b0;
        #1;
        chk_link("t6_rst_link", 2'b00, 4'h0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_ready", s_ready, 1'b1);
`ifdef NIB_LINK_TX_CNT_EN
        chk("cnt_rst", tx_cnt, 8'd0);
`endif
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_link("t6_post_link", 2'b00, 4'h0);
            chk("t6_post_busy", busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
